// File: rtl/osc_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : osc_edge_counter
// Purpose  : Ring-oscillator frequency measurement. The pre-divided oscillator
//            is synchronised into the clk domain and its rising edges are
//            counted over a programmable window of clk cycles. Each completed
//            window publishes a count with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of the edge counter and count output
//   WIN_W        width of the window-length input and window counter
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   en           measurement enable, back-to-back windows while high
//   osc_in       asynchronous oscillator input (period >= 4 clk)
//   win_len      window length in clk cycles, 0 behaves as 1
//   count        edge count of the last completed window
//   count_valid  one-cycle strobe when count updates
//   ovf          last completed window saturated the counter
//   busy         high while a window is in progress (ARM/COUNT/LATCH)
// Configuration macro
//   OSC_AVG4_EN  when defined, count is the average of four consecutive
//                windows and the strobe fires once per group of four
// ============================================================================
module osc_edge_counter #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             osc_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] C_WIN_ONE = WIN_W'(1);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_int;
    logic [WIN_W-1:0] r_win_cnt;

    logic             w_edge;
    logic             w_cnt_full;
    logic             w_win_last;
    logic             w_final_ovf;
    logic [CNT_W-1:0] w_final_cnt;
    logic [WIN_W-1:0] w_win_load;

    // Synchroniser and edge detector run independently of the FSM so that
    // the edge history stays valid across back-to-back windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge     = r_sync2 & ~r_hist;
    assign w_cnt_full = &r_edge_cnt;
    assign w_win_last = (r_win_cnt == C_WIN_ONE);
    assign w_win_load = (win_len == '0) ? C_WIN_ONE : win_len;

    // Result of the window including an edge that lands in its final cycle.
    // Saturation means an edge arrived with nowhere left to count it.
    assign w_final_cnt = (w_edge && !w_cnt_full) ? (r_edge_cnt + C_CNT_ONE) : r_edge_cnt;
    assign w_final_ovf = r_ovf_int | (w_edge & w_cnt_full);

`ifdef OSC_AVG4_EN
    logic [1:0]       r_win_idx;
    logic [CNT_W+1:0] r_acc;
    logic             r_ovf_acc;
    logic [CNT_W+1:0] w_acc_sum;

    // Two guard bits hold the sum of four full-scale windows without wrap.
    assign w_acc_sum = r_acc + {2'b00, w_final_cnt};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_edge_cnt  <= '0;
            r_ovf_int   <= 1'b0;
            r_win_cnt   <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            count_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef OSC_AVG4_EN
            r_win_idx   <= 2'd0;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
`endif
        end else begin
            count_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_ARM;
                        busy    <= 1'b1;
`ifdef OSC_AVG4_EN
                        r_win_idx <= 2'd0;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
`endif
                    end
                end

                S_ARM: begin
                    r_edge_cnt <= '0;
                    r_ovf_int  <= 1'b0;
                    r_win_cnt  <= w_win_load;
                    r_state    <= S_COUNT;
                end

                S_COUNT: begin
                    r_win_cnt <= r_win_cnt - C_WIN_ONE;
                    if (!en) begin
                        // Abort: published results are left untouched.
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
`ifdef OSC_AVG4_EN
                        r_win_idx <= 2'd0;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
`endif
                    end else if (w_win_last) begin
                        r_state <= S_LATCH;
`ifdef OSC_AVG4_EN
                        if (r_win_idx == 2'd3) begin
                            count       <= w_acc_sum[CNT_W+1:2];
                            ovf         <= r_ovf_acc | w_final_ovf;
                            count_valid <= 1'b1;
                            r_win_idx   <= 2'd0;
                            r_acc       <= '0;
                            r_ovf_acc   <= 1'b0;
                        end else begin
                            r_acc       <= w_acc_sum;
                            r_ovf_acc   <= r_ovf_acc | w_final_ovf;
                            r_win_idx   <= r_win_idx + 2'd1;
                        end
`else
                        count       <= w_final_cnt;
                        ovf         <= w_final_ovf;
                        count_valid <= 1'b1;
`endif
                    end else if (w_edge) begin
                        if (w_cnt_full) begin
                            r_ovf_int <= 1'b1;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + C_CNT_ONE;
                        end
                    end
                end

                S_LATCH: begin
                    if (en) begin
                        r_state <= S_ARM;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
